// File: rtl/ramdma_ctrl.sv
// ramdma_ctrl: CI-programmed DMA between the 512x32 scratchpad and a burst bus master port.
// Latency: CI access completes the same cycle; bus_req rises the cycle after a control start.
// Backpressure: bursts wait in REQ for bus_gnt; beats advance only on bus_beat_valid.
//
// Ports:
//   clock, reset            rising-edge clock, asynchronous active-high reset
//   start/ciN/valueA/valueB CI request (function in valueA[11:9], data in valueB)
//   done/result             CI response, combinational
//   mem_*                   scratchpad second port, 1-cycle read latency
//   bus_*                   burst bus master (req/gnt handshake, per-beat valid, error)
//   irq                     completion interrupt
// Optional feature: define RAMDMA_IRQ_EN to drive irq = cplt | error, cleared by a status read.
module ramdma_ctrl #(
    parameter logic [7:0] customId  = 8'h00,
    parameter int         MAX_BURST = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result,
    output logic [8:0]  mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        bus_req,
    input  logic        bus_gnt,
    output logic [31:0] bus_addr,
    output logic        bus_rnw,
    output logic [7:0]  bus_burst,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_beat_valid,
    input  logic        bus_error,
    output logic        irq
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_BEAT = 2'd2;

    localparam logic [9:0] MAX_B = 10'(MAX_BURST);

    logic [1:0]  state;
    logic [31:0] addr_q;     // bus byte address, advances per beat
    logic [8:0]  ptr_q;      // scratchpad word pointer, advances per beat
    logic [9:0]  len_q;      // programmed length (already clamped to 512)
    logic [9:0]  rem_q;      // beats left in the whole transfer
    logic [7:0]  beat_q;     // beats left in the current burst, minus one
    logic        rnw_q;
    logic        err_q;
    logic        cplt_q;

    logic        sel;
    logic [2:0]  func;
    logic        busy;
    logic        in_beat;
    logic [9:0]  rem_clamp;
    logic [9:0]  burst_m1;
    logic [9:0]  len_clamp;
    logic [31:0] status;

    assign sel       = start && (ciN == customId);
    assign func      = valueA[11:9];
    assign busy      = (state != S_IDLE);
    assign in_beat   = (state == S_BEAT);
    assign status    = {29'd0, cplt_q, err_q, busy};
    assign rem_clamp = (rem_q > MAX_B) ? MAX_B : rem_q;
    assign burst_m1  = rem_clamp - 10'd1;
    assign len_clamp = (valueB[9:0] > 10'd512) ? 10'd512 : valueB[9:0];

    assign done   = sel;
    assign result = (sel && (func == 3'd0)) ? status : 32'd0;

    // Look one word ahead on an accepted write beat so the next word is on
    // mem_rdata by the following cycle; this sustains back-to-back beats.
    assign mem_addr  = ptr_q + {8'd0, (in_beat && !rnw_q && bus_beat_valid)};
    assign mem_we    = in_beat && rnw_q && bus_beat_valid && !bus_error;
    assign mem_wdata = (in_beat && rnw_q) ? bus_rdata : 32'd0;

    assign bus_req   = (state == S_REQ);
    assign bus_addr  = addr_q;
    assign bus_rnw   = rnw_q;
    assign bus_burst = bus_req ? burst_m1[7:0] : 8'd0;
    assign bus_wdata = (in_beat && !rnw_q) ? mem_rdata : 32'd0;

`ifdef RAMDMA_IRQ_EN
    assign irq = cplt_q | err_q;
`else
    assign irq = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S_IDLE;
            addr_q <= 32'd0;
            ptr_q  <= 9'd0;
            len_q  <= 10'd0;
            rem_q  <= 10'd0;
            beat_q <= 8'd0;
            rnw_q  <= 1'b0;
            err_q  <= 1'b0;
            cplt_q <= 1'b0;
        end else begin
`ifdef RAMDMA_IRQ_EN
            // Status read acknowledges the interrupt; a completion on the same
            // edge is assigned below and therefore wins.
            if (sel && (func == 3'd0)) begin
                err_q  <= 1'b0;
                cplt_q <= 1'b0;
            end
`endif
            case (state)
                S_IDLE: begin
                    if (sel) begin
                        case (func)
                            3'd1: addr_q <= valueB;
                            3'd2: ptr_q  <= valueB[8:0];
                            3'd3: len_q  <= len_clamp;
                            3'd4: begin
                                case (valueB[1:0])
                                    2'd1, 2'd2: begin
                                        rnw_q <= (valueB[1:0] == 2'd1);
                                        err_q <= 1'b0;
                                        rem_q <= len_q;
                                        if (len_q == 10'd0) begin
                                            cplt_q <= 1'b1;
                                        end else begin
                                            cplt_q <= 1'b0;
                                            state  <= S_REQ;
                                        end
                                    end
                                    2'd3: begin
                                        err_q  <= 1'b1;
                                        cplt_q <= 1'b0;
                                    end
                                    default: ;
                                endcase
                            end
                            default: ;
                        endcase
                    end
                end
                S_REQ: begin
                    if (bus_gnt) begin
                        beat_q <= burst_m1[7:0];
                        state  <= S_BEAT;
                    end
                end
                S_BEAT: begin
                    if (bus_error) begin
                        state  <= S_IDLE;
                        err_q  <= 1'b1;
                        cplt_q <= 1'b0;
                    end else if (bus_beat_valid) begin
                        ptr_q  <= ptr_q + 9'd1;
                        addr_q <= addr_q + 32'd4;
                        rem_q  <= rem_q - 10'd1;
                        beat_q <= beat_q - 8'd1;
                        if (beat_q == 8'd0) begin
                            if (rem_q == 10'd1) begin
                                state  <= S_IDLE;
                                cplt_q <= 1'b1;
                            end else begin
                                state  <= S_REQ;
                            end
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic unused_bits;
    assign unused_bits = ^{valueA[31:12], valueA[8:0], burst_m1[9:8]};

endmodule

// File: tb/tb_ramdma_ctrl.sv
module tb_ramdma_ctrl;

    localparam int MB = 16;
`ifdef RAMDMA_IRQ_EN
    localparam bit IRQB = 1'b1;
`else
    localparam bit IRQB = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic        done;
    logic [31:0] result;
    logic [8:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        bus_req;
    logic        bus_gnt;
    logic [31:0] bus_addr;
    logic        bus_rnw;
    logic [7:0]  bus_burst;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_beat_valid;
    logic        bus_error;
    logic        irq;

    always #5 clock = ~clock;

    ramdma_ctrl #(.customId(8'h00), .MAX_BURST(MB)) dut (
        .clock(clock), .reset(reset), .start(start), .ciN(ciN),
        .valueA(valueA), .valueB(valueB), .done(done), .result(result),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .bus_req(bus_req), .bus_gnt(bus_gnt),
        .bus_addr(bus_addr), .bus_rnw(bus_rnw), .bus_burst(bus_burst),
        .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .bus_beat_valid(bus_beat_valid), .bus_error(bus_error), .irq(irq)
    );

    // Scratchpad model: 512 words, 1-cycle read latency.
    logic [31:0] mem_m [512];
    always @(posedge clock) begin
        if (mem_we) mem_m[mem_addr] <= mem_wdata;
        mem_rdata <= mem_m[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Bus slave: logs each requested burst and each beat's data.
    typedef struct {
        logic [31:0] addr;
        logic        rnw;
        logic [7:0]  burst;
    } burst_t;

    burst_t      burst_q [$];
    logic [31:0] beat_q  [$];
    burst_t      cur;
    int gnt_prob = 100, beat_prob = 100, err_beat = -1;
    int beat_idx = 0, beats_left = 0, stab_bad = 0;
    bit in_burst = 1'b0, req_seen = 1'b0;

    initial begin
        bus_gnt = 1'b0; bus_beat_valid = 1'b0; bus_error = 1'b0; bus_rdata = 32'd0;
    end

    always @(negedge clock) begin
        bus_gnt = 1'b0; bus_beat_valid = 1'b0; bus_error = 1'b0;
        if (reset) begin
            in_burst = 1'b0; req_seen = 1'b0;
        end else if (in_burst) begin
            if (err_beat >= 0 && beat_idx == err_beat) begin
                bus_error = 1'b1;
                in_burst  = 1'b0;
            end else if ($urandom_range(0, 99) < beat_prob) begin
                bus_beat_valid = 1'b1;
                bus_rdata = $urandom;
                #1;
                if (cur.rnw) beat_q.push_back(bus_rdata);
                else         beat_q.push_back(bus_wdata);
                beat_idx++;
                beats_left--;
                if (beats_left == 0) in_burst = 1'b0;
            end
        end else if (bus_req) begin
            if (!req_seen) begin
                cur.addr = bus_addr; cur.rnw = bus_rnw; cur.burst = bus_burst;
                burst_q.push_back(cur);
                req_seen = 1'b1;
            end else if (bus_addr !== cur.addr || bus_rnw !== cur.rnw || bus_burst !== cur.burst) begin
                stab_bad++;
            end
            if ($urandom_range(0, 99) < gnt_prob) begin
                bus_gnt    = 1'b1;
                in_burst   = 1'b1;
                beats_left = int'(bus_burst) + 1;
                req_seen   = 1'b0;
            end
        end
    end

    task automatic ci_wr(input logic [2:0] f, input logic [31:0] vb);
        @(negedge clock);
        start = 1'b1; ciN = 8'h00; valueA = $urandom; valueA[11:9] = f; valueB = vb;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic ci_rd(output logic [31:0] r);
        @(negedge clock);
        start = 1'b1; ciN = 8'h00; valueA = $urandom; valueA[11:9] = 3'd0; valueB = $urandom;
        #1 r = result;
        @(posedge clock); #1 start = 1'b0;
    endtask

    task automatic wait_idle(output logic [31:0] st, output logic irq_end, output logic irq_after);
        bit fin = 1'b0;
        st = '1; irq_end = 1'b0;
        for (int c = 0; c < 6000 && !fin; c++) begin
            @(negedge clock);
            start = 1'b1; ciN = 8'h00; valueA = 32'd0; valueB = 32'd0;
            #1 st = result; irq_end = irq;
            @(posedge clock); #1 start = 1'b0;
            if (!st[0]) fin = 1'b1;
        end
        irq_after = irq;
        chk("idle_reached", {31'd0, fin}, 32'd1);
    endtask

    // Program, run and check one transfer against the arithmetic model.
    task automatic do_xfer(input logic [1:0] dir, input logic [31:0] a, input logic [8:0] p,
                           input logic [31:0] lraw, input int gp, input int bp, input int e,
                           input bit poke);
        logic [31:0] snap [512];
        logic [31:0] st, eaddr;
        logic ie, ia;
        int L, nb, nbeat, diff, idx, bl;
        gnt_prob = gp; beat_prob = bp; err_beat = e; beat_idx = 0; stab_bad = 0;
        burst_q.delete(); beat_q.delete();
        ci_wr(3'd1, a);
        ci_wr(3'd2, {23'd0, p});
        ci_wr(3'd3, lraw);
        for (int i = 0; i < 512; i++) snap[i] = mem_m[i];
        ci_wr(3'd4, {30'd0, dir});
        if (poke) begin
            // All ignored while busy.
            ci_wr(3'd1, ~a);
            ci_wr(3'd2, {23'd0, ~p});
            ci_wr(3'd3, 32'd7);
            ci_wr(3'd4, 32'd3);
        end
        wait_idle(st, ie, ia);

        L = int'(lraw[9:0]);
        if (L > 512) L = 512;
        nbeat = (e >= 0) ? e : L;
        nb = 0;
        for (int off = 0; off < L && (e < 0 || off <= e); off += MB) begin
            bl = (L - off < MB) ? (L - off) : MB;
            eaddr = a + 32'(4 * off);
            if (nb < burst_q.size()) begin
                chk("burst_addr", burst_q[nb].addr, eaddr);
                chk("burst_rnw", {31'd0, burst_q[nb].rnw}, {31'd0, (dir == 2'd1)});
                chk("burst_len", {24'd0, burst_q[nb].burst}, 32'(bl - 1));
            end
            nb++;
        end
        chk("burst_count", 32'(burst_q.size()), 32'(nb));
        chk("beat_count", 32'(beat_q.size()), 32'(nbeat));
        for (int k = 0; k < nbeat && k < beat_q.size(); k++) begin
            idx = (int'(p) + k) % 512;
            if (dir == 2'd1) chk("mem_written", mem_m[idx], beat_q[k]);
            else             chk("bus_wdata", beat_q[k], snap[idx]);
        end
        diff = 0;
        for (int i = 0; i < 512; i++) begin
            if ((dir != 2'd1 || ((i - int'(p) + 512) % 512) >= nbeat) && mem_m[i] !== snap[i])
                diff++;
        end
        chk("mem_untouched", 32'(diff), 32'd0);
        chk("status_end", st, (e >= 0) ? 32'h2 : 32'h4);
        chk("irq_at_end", {31'd0, ie}, {31'd0, IRQB});
        chk("irq_after_read", {31'd0, ia}, 32'd0);
        chk("req_stable", 32'(stab_bad), 32'd0);
    endtask

    typedef struct {
        logic [7:0]  ci;
        logic [2:0]  func;
        logic [31:0] vb;
        logic        exp_done;
        logic [31:0] exp_res;
        logic        exp_irq;
    } vec_t;

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt [17];
        logic [31:0] r, lraw, a;
        logic [8:0] p;
        int cnt, lm, e, dir;
        bit reached;

        for (int i = 0; i < 512; i++) mem_m[i] = $urandom;
        reset = 1'b1; start = 1'b0; ciN = 8'h00; valueA = 32'd0; valueB = 32'd0;

        // Reset state
        @(negedge clock); #1;
        chk("rst_ctl", {27'd0, bus_req, mem_we, irq, done, bus_rnw}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_burst", {24'd0, bus_burst}, 32'd0);
        chk("rst_mem_addr", {23'd0, mem_addr}, 32'd0);
        chk("rst_data", bus_wdata | mem_wdata | result, 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // CI register-level vectors (back-to-back, one per cycle)
        vt[0]  = '{8'h00, 3'd0, 32'd0,        1'b1, 32'd0,                 1'b0};
        vt[1]  = '{8'h05, 3'd0, 32'd0,        1'b0, 32'd0,                 1'b0};
        vt[2]  = '{8'h00, 3'd5, 32'hFFFFFFFF, 1'b1, 32'd0,                 1'b0};
        vt[3]  = '{8'h00, 3'd6, 32'hFFFFFFFF, 1'b1, 32'd0,                 1'b0};
        vt[4]  = '{8'h00, 3'd7, 32'hFFFFFFFF, 1'b1, 32'd0,                 1'b0};
        vt[5]  = '{8'h00, 3'd4, 32'd3,        1'b1, 32'd0,                 1'b0};
        vt[6]  = '{8'h00, 3'd0, 32'd0,        1'b1, 32'h2,                 IRQB};
        vt[7]  = '{8'h00, 3'd0, 32'd0,        1'b1, IRQB ? 32'h0 : 32'h2,  1'b0};
        vt[8]  = '{8'h00, 3'd3, 32'd0,        1'b1, 32'd0,                 1'b0};
        vt[9]  = '{8'h00, 3'd4, 32'd1,        1'b1, 32'd0,                 1'b0};
        vt[10] = '{8'h00, 3'd0, 32'd0,        1'b1, 32'h4,                 IRQB};
        vt[11] = '{8'h00, 3'd4, 32'd0,        1'b1, 32'd0,                 1'b0};
        vt[12] = '{8'h00, 3'd0, 32'd0,        1'b1, IRQB ? 32'h0 : 32'h4,  1'b0};
        vt[13] = '{8'h00, 3'd4, 32'd3,        1'b1, 32'd0,                 1'b0};
        vt[14] = '{8'h00, 3'd0, 32'd0,        1'b1, 32'h2,                 IRQB};
        vt[15] = '{8'hFF, 3'd4, 32'd1,        1'b0, 32'd0,                 1'b0};
        vt[16] = '{8'h00, 3'd0, 32'd0,        1'b1, IRQB ? 32'h0 : 32'h2,  1'b0};
        for (int i = 0; i < 17; i++) begin
            @(negedge clock);
            start = 1'b1; ciN = vt[i].ci; valueA = $urandom; valueA[11:9] = vt[i].func;
            valueB = vt[i].vb;
            #1;
            chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vt[i].exp_done});
            chk($sformatf("vec%0d_result", i), result, vt[i].exp_res);
            chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
            chk($sformatf("vec%0d_no_req", i), {31'd0, bus_req}, 32'd0);
        end
        @(posedge clock); #1 start = 1'b0;

        // Read 40 words across the scratchpad wrap: bursts 15/15/7
        do_xfer(2'd1, 32'h0000_1000, 9'h1F8, 32'd40, 60, 70, -1, 1'b0);
        // Write 3 words, slave accepts every cycle
        do_xfer(2'd2, 32'h0000_2000, 9'h010, 32'd3, 100, 100, -1, 1'b0);
        // Error on beat 2, then no further requests
        do_xfer(2'd2, 32'h0000_4000, 9'h020, 32'd10, 100, 100, 2, 1'b0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clock); #1;
            if (bus_req) cnt++;
        end
        chk("no_req_after_error", 32'(cnt), 32'd0);
        // Register writes while busy are ignored
        do_xfer(2'd1, 32'h0000_5000, 9'h100, 32'd20, 5, 60, -1, 1'b1);
        // Length clamp to 512 and upper bits ignored
        do_xfer(2'd2, 32'hFFFF_FF00, 9'h0AB, 32'h0000_03FF, 100, 100, -1, 1'b0);
        do_xfer(2'd1, 32'h0000_6000, 9'h1FE, 32'hFFFF_0005, 100, 100, -1, 1'b0);
        // Length 0 completes without a bus access
        do_xfer(2'd1, 32'h0000_7000, 9'h000, 32'd0, 100, 100, -1, 1'b0);

        // Reset while in BEAT
        gnt_prob = 100; beat_prob = 100; err_beat = -1; beat_idx = 0;
        burst_q.delete(); beat_q.delete();
        ci_wr(3'd1, 32'h0000_3000);
        ci_wr(3'd2, 32'd0);
        ci_wr(3'd3, 32'd40);
        ci_wr(3'd4, 32'd1);
        reached = 1'b0;
        for (int c = 0; c < 100 && !reached; c++) begin
            @(negedge clock); #2;
            if (in_burst && beat_idx >= 2) reached = 1'b1;
        end
        chk("rst_test_reach", {31'd0, reached}, 32'd1);
        @(negedge clock); #2;
        chk("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_rst_outputs", {29'd0, bus_req, mem_we, irq}, 32'd0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        ci_rd(r);
        chk("post_rst_status", r, 32'd0);
        chk("post_rst_bus_addr", bus_addr, 32'd0);

        // Randomized transfers
        for (int t = 0; t < 14; t++) begin
            dir = int'($urandom_range(1, 2));
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0) a = 32'hFFFF_FFE0;
            p = 9'($urandom_range(0, 511));
            if ($urandom_range(0, 9) == 0) lraw = ($urandom & 32'hFFFF_FC00) | 32'($urandom_range(513, 1023));
            else                           lraw = 32'($urandom_range(0, 48));
            lm = int'(lraw[9:0]);
            if (lm > 512) lm = 512;
            e = -1;
            if (lm > 0 && $urandom_range(0, 3) == 0) e = int'($urandom_range(0, lm - 1));
            do_xfer(2'(dir), a, p, lraw, int'($urandom_range(20, 100)),
                    int'($urandom_range(30, 100)), e, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ramdma_ctrl.md
# ramdma_ctrl

Custom-instruction-programmed DMA controller that moves word blocks between the 512×32 CI scratchpad and the system bus. Software sets the bus address, scratchpad address, block length and direction through CI writes, then polls status. The block splits the transfer into bursts of at most `MAX_BURST` beats and drives the scratchpad's second port and a bus-master port.

## Interface
- `customId`, 8'h00, CI number this block answers to
- `MAX_BURST`, 16, maximum beats per bus burst (1..256)

- `clock`  in  1  system clock, all logic on rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  CI start strobe
- `ciN`  in  8  CI number; block is selected when `ciN == customId` and `start`
- `valueA`  in  32  CI operand A; `valueA[11:9]` = function
- `valueB`  in  32  CI operand B; write data
- `done`  out  1  CI done
- `result`  out  32  CI result
- `mem_addr`  out  9  scratchpad address (1-cycle read latency)
- `mem_we`  out  1  scratchpad write enable
- `mem_wdata`  out  32  scratchpad write data
- `mem_rdata`  in  32  scratchpad read data
- `bus_req`  out  1  burst request
- `bus_gnt`  in  1  burst granted
- `bus_addr`  out  32  burst start byte address
- `bus_rnw`  out  1  1 = bus→scratchpad, 0 = scratchpad→bus
- `bus_burst`  out  8  beats−1
- `bus_wdata`  out  32  write beat data
- `bus_rdata`  in  32  read beat data
- `bus_beat_valid`  in  1  slave accepts/provides one beat this cycle
- `bus_error`  in  1  slave error, valid during BEAT
- `irq`  out  1  completion interrupt

## Operation
- `done` = selected, combinational, same cycle; `result` = 0 unless selected.
- Functions: 0 = read status `{29'b0, cplt, error, busy}`; 1 = bus address ← `valueB`; 2 = scratchpad address ← `valueB[8:0]`; 3 = length ← `valueB[9:0]`, values >512 clamp to 512; 4 = control, `valueB[1:0]`: 1 read (bus→mem), 2 write (mem→bus), 0 no-op, 3 illegal; 5–7 no effect, result 0.
- Functions 1–4 are ignored while busy; status read is always allowed.
- Control start clears `error` and `cplt`. A length of 0 sets `cplt` without a bus access. An illegal direction sets `error` and stays IDLE.
- FSM states:
  - IDLE → REQ on a valid start.
  - REQ: `bus_req`=1, `bus_addr`/`bus_rnw`/`bus_burst` held stable, `bus_burst` = min(remaining, `MAX_BURST`)−1. `bus_gnt` → BEAT.
  - BEAT: on each `bus_beat_valid`, scratchpad pointer +1 (wraps 511→0), bus address +4 (wraps at 2^32), remaining −1.
    - Read direction: `mem_we`=1, `mem_wdata`=`bus_rdata`.
    - Write direction: `bus_wdata`=`mem_rdata`.
  - Last beat of a burst → REQ if remaining > 0, else IDLE with `cplt`=1.
  - `bus_error` in BEAT → IDLE, `error`=1, `cplt`=0; remaining beats abandoned.
- `mem_addr` = pointer + (BEAT & write dir & `bus_beat_valid`), combinational, so back-to-back write beats are sustained.

## Timing
- Reset: all outputs 0, FSM IDLE, all registers 0; asserting reset mid-transfer drops `bus_req` immediately (async).
- Register write visible from the next edge; `bus_req` rises the cycle after a control start; `busy` reads 1 in that same next cycle.
- REQ lasts ≥1 cycle, which guarantees the first write word is on `mem_rdata` before the first beat.
- `bus_req` falls on the edge where `bus_gnt` is sampled high.
- Simultaneous status read and transfer end: the read returns the pre-edge value.

## Configuration
- `RAMDMA_IRQ_EN` defined: `irq` = `cplt | error`, level; cleared by a status read (function 0) on that edge.
- `RAMDMA_IRQ_EN` undefined: `irq` tied 0, no IRQ logic; `cplt`/`error` are cleared only by a new control start.

## Test plan
- Reset while in BEAT → `bus_req`/`mem_we`/`irq` = 0 at once; status reads 0.
- Read, length 40, `MAX_BURST`=16, bus 0x1000, mem 0x1F8 → bursts 15/15/7 at 0x1000/0x1040/0x1080; mem writes to 0x1F8..0x1FF then 0x000..0x01F; status ends 0x4.
- Write, length 3, slave accepts 3 consecutive cycles → `bus_wdata` = mem[a], mem[a+1], mem[a+2] with no bubble.
- `bus_error` on beat 2 → IDLE, status 0x2, no further `bus_req`.
- Control 3 → status 0x2, no `bus_req`; length 0 start → status 0x4 next cycle.
- Function 1 write while busy → bus address unchanged; with `RAMDMA_IRQ_EN`, `irq` 1 after completion and 0 after a status read.
